// File: rtl/four_one_mux.sv
// four_one_mux: 4-to-1 lane selector.
// Y and sel_onehot are combinational and follow I/S with zero latency.
// y_q, sel_q and y_valid are registered copies, loaded on enabled clock edges.
// An asynchronous active-low reset clears the registered outputs immediately.
module four_one_mux #(
    parameter int WIDTH = 1
) (
    input  logic [4*WIDTH-1:0] I,
    input  logic [1:0]         S,
    output logic [WIDTH-1:0]   Y,
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [WIDTH-1:0]   y_q,
    output logic               y_valid,
    output logic [3:0]         sel_onehot,
    output logic [1:0]         sel_q
);

    // Whole-lane selection; an unknown select yields an unknown lane.
    function automatic logic [WIDTH-1:0] pick_lane(
        input logic [4*WIDTH-1:0] lanes,
        input logic [1:0]         sel
    );
        logic [WIDTH-1:0] res;
        case (sel)
            2'b00:   res = lanes[0*WIDTH +: WIDTH];
            2'b01:   res = lanes[1*WIDTH +: WIDTH];
            2'b10:   res = lanes[2*WIDTH +: WIDTH];
            2'b11:   res = lanes[3*WIDTH +: WIDTH];
            default: res = {WIDTH{1'bx}};
        endcase
        return res;
    endfunction

    // One-hot decode of the select; an unknown select decodes to unknown.
    function automatic logic [3:0] decode_sel(input logic [1:0] sel);
        logic [3:0] res;
        case (sel)
            2'b00:   res = 4'b0001;
            2'b01:   res = 4'b0010;
            2'b10:   res = 4'b0100;
            2'b11:   res = 4'b1000;
            default: res = 4'bxxxx;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] y_d;
    logic [1:0]       sel_d;
    logic             valid_d;

    // Combinational selected lane, independent of clk, rst_n and en.
    always_comb begin
        Y = pick_lane(I, S);
    end

    // Combinational one-hot view of the current select.
    always_comb begin
        sel_onehot = decode_sel(S);
    end

    // Next-state: capture the live selection on enable, otherwise hold.
    always_comb begin
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = y_valid;
        if (en) begin
            y_d     = Y;
            sel_d   = S;
            valid_d = 1'b1;
        end else begin
            y_d     = y_q;
            sel_d   = sel_q;
            valid_d = y_valid;
        end
    end

    // Registered copy of the selection; reset clears it without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= {WIDTH{1'b0}};
            sel_q   <= 2'b00;
            y_valid <= 1'b0;
        end else begin
            y_q     <= y_d;
            sel_q   <= sel_d;
            y_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_four_one_mux.sv
// Bench for four_one_mux: directed checks from the test plan, then randomized
// traffic with a queue-based scoreboard for the registered path.
module tb_four_one_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  S;
    logic [3:0]  I1;
    logic [31:0] I8;
    logic [0:0]  Y1, yq1;
    logic [7:0]  Y8, yq8;
    logic        vld1, vld8;
    logic [3:0]  oh1, oh8;
    logic [1:0]  selq1, selq8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:0] yq1;
        logic [7:0] yq8;
        logic [1:0] sel;
        logic       valid;
    } exp_t;

    exp_t sb_q[$];

    four_one_mux #(.WIDTH(1)) u1 (
        .I(I1), .S(S), .Y(Y1), .clk(clk), .rst_n(rst_n), .en(en),
        .y_q(yq1), .y_valid(vld1), .sel_onehot(oh1), .sel_q(selq1)
    );

    four_one_mux #(.WIDTH(8)) u8 (
        .I(I8), .S(S), .Y(Y8), .clk(clk), .rst_n(rst_n), .en(en),
        .y_q(yq8), .y_valid(vld8), .sel_onehot(oh8), .sel_q(selq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: lane number s taken out of the packed word by shifting.
    function automatic logic [0:0] ref1(input logic [3:0] i, input logic [1:0] s);
        return 1'((i >> s) & 4'h1);
    endfunction

    function automatic logic [7:0] ref8(input logic [31:0] i, input logic [1:0] s);
        return 8'((i >> (32'(s) * 8)) & 32'hFF);
    endfunction

    // Monitor: after every clock edge compare registered outputs with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_yq1",   32'(yq1),   32'(e.yq1));
                chk("sb_yq8",   32'(yq8),   32'(e.yq8));
                chk("sb_selq1", 32'(selq1), 32'(e.sel));
                chk("sb_selq8", 32'(selq8), 32'(e.sel));
                chk("sb_vld1",  32'(vld1),  32'(e.valid));
                chk("sb_vld8",  32'(vld8),  32'(e.valid));
            end
        end
    end

    // Directed test-plan pairs for WIDTH=1.
    logic [1:0] tp_s [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b11};
    logic [3:0] tp_i [9] = '{4'b1010, 4'b0101, 4'b0110, 4'b1001, 4'b1001, 4'b1100, 4'b1110, 4'b0001, 4'b0010};
    logic       tp_y [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [0:0] m_yq1;
        logic [7:0] m_yq8;
        logic [1:0] m_sel;
        logic       m_valid;
        exp_t       e;

        rst_n = 1'b1;
        en    = 1'b0;
        S     = 2'b00;
        I1    = 4'h0;
        I8    = 32'h0;

        // Asynchronous reset before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_yq1",   32'(yq1),   32'h0);
        chk("rst_yq8",   32'(yq8),   32'h0);
        chk("rst_selq1", 32'(selq1), 32'h0);
        chk("rst_vld1",  32'(vld1),  32'h0);
        chk("rst_vld8",  32'(vld8),  32'h0);

        // Combinational Y, 100 ns apart.
        for (int k = 0; k < 9; k++) begin
            #100;
            S  = tp_s[k];
            I1 = tp_i[k];
            #1;
            chk($sformatf("y1_pair%0d", k), 32'(Y1), 32'(tp_y[k]));
        end

        // One-hot decode.
        for (int k = 0; k < 4; k++) begin
            S = 2'(k);
            #1;
            chk($sformatf("onehot_s%0d", k), 32'(oh1), 32'(4'b0001 << k));
            chk($sformatf("onehot8_s%0d", k), 32'(oh8), 32'(4'b0001 << k));
        end

        // WIDTH=8 whole-lane selection.
        I8 = 32'hDDCCBBAA;
        S  = 2'b11;
        #1 chk("y8_s3", 32'(Y8), 32'hDD);
        S  = 2'b01;
        #1 chk("y8_s1", 32'(Y8), 32'hBB);

        // First enabled load after releasing reset.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        S     = 2'b10;
        I1    = 4'b0100;
        I8    = 32'h11223344;
        @(posedge clk);
        #1;
        chk("load_yq1",   32'(yq1),   32'h1);
        chk("load_selq1", 32'(selq1), 32'h2);
        chk("load_vld1",  32'(vld1),  32'h1);
        chk("load_yq8",   32'(yq8),   32'h22);

        // Enable low: inputs change, registers hold across three edges.
        @(negedge clk);
        en = 1'b0;
        S  = 2'b00;
        I1 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_y1",    32'(Y1),    32'h0);
        chk("hold_yq1",   32'(yq1),   32'h1);
        chk("hold_selq1", 32'(selq1), 32'h2);
        chk("hold_vld1",  32'(vld1),  32'h1);
        chk("hold_yq8",   32'(yq8),   32'h22);

        // Reset pulse between edges clears registers at once; Y still tracks.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_yq1",   32'(yq1),   32'h0);
        chk("mid_yq8",   32'(yq8),   32'h0);
        chk("mid_selq1", 32'(selq1), 32'h0);
        chk("mid_vld1",  32'(vld1),  32'h0);
        I1 = 4'b1000;
        S  = 2'b11;
        #1 chk("mid_y1", 32'(Y1), 32'h1);

        // Randomized traffic against the reference model and scoreboard.
        @(negedge clk);
        rst_n   = 1'b1;
        m_yq1   = 1'b0;
        m_yq8   = 8'h00;
        m_sel   = 2'b00;
        m_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            S  = 2'($urandom_range(3, 0));
            en = 1'($urandom_range(1, 0));
            I1 = 4'($urandom);
            I8 = $urandom;
            #1;
            chk("rnd_y1", 32'(Y1), 32'(ref1(I1, S)));
            chk("rnd_y8", 32'(Y8), 32'(ref8(I8, S)));
            chk("rnd_oh", 32'(oh8), 32'(4'b0001 << S));
            if (en) begin
                m_yq1   = ref1(I1, S);
                m_yq8   = ref8(I8, S);
                m_sel   = S;
                m_valid = 1'b1;
            end
            e.yq1   = m_yq1;
            e.yq8   = m_yq8;
            e.sel   = m_sel;
            e.valid = m_valid;
            sb_q.push_back(e);
            @(negedge clk);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
